// File: rtl/mips_alu_serial_seq_if.sv
// Bus between the bit-serial ALU sequencer and its environment: the request/result
// side plus the per-bit drive to and capture from the external 1-bit ALU slice.
interface mips_alu_serial_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       aluop;
    logic             slice_a;
    logic             slice_b;
    logic             slice_ci;
    logic             slice_less;
    logic [2:0]       slice_op;
    logic             slice_r;
    logic             slice_c;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    // master is the environment: it issues requests and hosts the 1-bit slice
    modport master (
        output start, a, b, aluop, slice_r, slice_c,
        input  slice_a, slice_b, slice_ci, slice_less, slice_op,
               busy, done, result, zero, cout, overflow
    );

    modport slave (
        input  start, a, b, aluop, slice_r, slice_c,
        output slice_a, slice_b, slice_ci, slice_less, slice_op,
               busy, done, result, zero, cout, overflow
    );
endinterface

// File: rtl/mips_alu_serial_seq.sv
// Bit-serial sequencer that walks one external 1-bit ALU slice over a WIDTH-bit
// operation, LSB first; SLT takes an extra subtract pass to find the sign of a-b.
module mips_alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mips_alu_serial_seq_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic             set_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             lastIdx;

    assign lastIdx = (idx_q == IW'(WIDTH - 1));

    assign bus.slice_a    = a_q[idx_q];
    assign bus.slice_b    = b_q[idx_q];
    assign bus.slice_ci   = carry_q;
    assign bus.slice_op   = (state_q == PASS1) ? 3'b110 : op_q;
    // The sign found in the first SLT pass enters only at bit 0 of the second pass
    assign bus.slice_less = (state_q == PASS2) && (idx_q == '0) && (op_q == 3'b111) && set_q;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

    always_comb begin
        result_d = result_q;
        if (state_q == PASS2) begin
            result_d[idx_q] = bus.slice_r;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            set_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.aluop;
                        idx_q   <= '0;
                        carry_q <= bus.aluop[2];
                        busy_q  <= 1'b1;
                        state_q <= (bus.aluop == 3'b111) ? PASS1 : PASS2;
                    end
                end
                PASS1: begin
                    carry_q <= bus.slice_c;
                    idx_q   <= idx_q + IW'(1);
                    if (lastIdx) begin
                        set_q   <= bus.slice_r;
                        cout_q  <= bus.slice_c;
                        ovf_q   <= 1'b0;
                        idx_q   <= '0;
                        carry_q <= 1'b1;
                        state_q <= PASS2;
                    end
                end
                PASS2: begin
                    result_q <= result_d;
                    carry_q  <= bus.slice_c;
                    idx_q    <= idx_q + IW'(1);
                    if (lastIdx) begin
                        if (op_q != 3'b111) begin
                            cout_q <= bus.slice_c;
                            ovf_q  <= (op_q[1:0] == 2'b10) & (carry_q ^ bus.slice_c);
                        end
                        zero_q  <= (result_d == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_alu_serial_seq.sv
// Self-checking bench for mips_alu_serial_seq: models the external 1-bit slice,
// runs a table of directed vectors, hand-written corner sequences and random ops.
module tb_mips_alu_serial_seq;
    localparam int W = 32;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
        int           lat;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    vec_t vecs[9];

    mips_alu_serial_seq_if #(.WIDTH(W)) ifc ();

    mips_alu_serial_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 1-bit ALU slice: op[2] inverts b, op[1:0] picks AND/OR/SUM/LESS
    logic sliceBx;
    assign sliceBx     = ifc.slice_b ^ ifc.slice_op[2];
    assign ifc.slice_c = (ifc.slice_a & sliceBx) | (ifc.slice_a & ifc.slice_ci) | (sliceBx & ifc.slice_ci);
    assign ifc.slice_r = (ifc.slice_op[1:0] == 2'b00) ? (ifc.slice_a & sliceBx) :
                         (ifc.slice_op[1:0] == 2'b01) ? (ifc.slice_a | sliceBx) :
                         (ifc.slice_op[1:0] == 2'b10) ? (ifc.slice_a ^ sliceBx ^ ifc.slice_ci) :
                                                        ifc.slice_less;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Whole-word view of the operation: b optionally inverted, one wide add
    function automatic void refModel(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                     output logic [W-1:0] r, output logic c, output logic v);
        logic [W-1:0] bx;
        logic [W:0]   sum;
        bx  = op[2] ? ~bv : bv;
        sum = {1'b0, av} + {1'b0, bx} + {{W{1'b0}}, op[2]};
        case (op[1:0])
            2'b00:   r = av & bx;
            2'b01:   r = av | bx;
            2'b10:   r = sum[W-1:0];
            default: r = (op == 3'b111) ? {{(W-1){1'b0}}, sum[W-1]} : '0;
        endcase
        c = sum[W];
        v = (op[1:0] == 2'b10) && (av[W-1] == bx[W-1]) && (sum[W-1] != av[W-1]);
    endfunction

    // Issue one op and wait for done; lat counts posedges from the start-sampling edge
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input int injAt, input logic [W-1:0] injA, output int lat);
        bit ok;
        @(negedge clk);
        ifc.a     = av;
        ifc.b     = bv;
        ifc.aluop = op;
        ifc.start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        ifc.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 4 * W; k++) begin
            if (ifc.done) begin
                ok = 1'b1;
                break;
            end
            if (lat == injAt) begin
                ifc.start = 1'b1;
                ifc.a     = injA;
            end else begin
                ifc.start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ifc.start = 1'b0;
        checkOutput("done_seen", {63'd0, ok}, 64'd1);
    endtask

    task automatic runChecked(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input int injAt, input logic [W-1:0] injA);
        int           lat;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        refModel(op, av, bv, r, c, v);
        applyStimulus(op, av, bv, injAt, injA, lat);
        checkOutput({tag, "_result"}, 64'(ifc.result), 64'(r));
        checkOutput({tag, "_zero"}, 64'(ifc.zero), 64'(r == '0));
        checkOutput({tag, "_cout"}, 64'(ifc.cout), 64'(c));
        checkOutput({tag, "_ovf"}, 64'(ifc.overflow), 64'(v));
        checkOutput({tag, "_latency"}, 64'(lat), (op == 3'b111) ? 64'(2 * W + 1) : 64'(W + 1));
    endtask

    initial begin
        int lat;
        bit sawDone;
        checks    = 0;
        errors    = 0;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.aluop = '0;

        vecs[0] = '{op: 3'b010, a: 32'd5,          b: 32'd7,          r: 32'h0000000C, z: 1'b0, c: 1'b0, v: 1'b0, lat: 33};
        vecs[1] = '{op: 3'b110, a: 32'd3,          b: 32'd5,          r: 32'hFFFFFFFE, z: 1'b0, c: 1'b0, v: 1'b0, lat: 33};
        vecs[2] = '{op: 3'b110, a: 32'd9,          b: 32'd9,          r: 32'h00000000, z: 1'b1, c: 1'b1, v: 1'b0, lat: 33};
        vecs[3] = '{op: 3'b111, a: 32'd3,          b: 32'd5,          r: 32'h00000001, z: 1'b0, c: 1'b0, v: 1'b0, lat: 65};
        vecs[4] = '{op: 3'b111, a: 32'd5,          b: 32'd3,          r: 32'h00000000, z: 1'b1, c: 1'b1, v: 1'b0, lat: 65};
        vecs[5] = '{op: 3'b010, a: 32'h7FFFFFFF,   b: 32'd1,          r: 32'h80000000, z: 1'b0, c: 1'b0, v: 1'b1, lat: 33};
        vecs[6] = '{op: 3'b000, a: 32'hF0F0F0F0,   b: 32'hFF00FF00,   r: 32'hF000F000, z: 1'b0, c: 1'b1, v: 1'b0, lat: 33};
        vecs[7] = '{op: 3'b001, a: 32'hF0F0F0F0,   b: 32'hFF00FF00,   r: 32'hFFF0FFF0, z: 1'b0, c: 1'b1, v: 1'b0, lat: 33};
        vecs[8] = '{op: 3'b110, a: 32'h80000000,   b: 32'd1,          r: 32'h7FFFFFFF, z: 1'b0, c: 1'b1, v: 1'b1, lat: 33};

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(ifc.busy), 64'd0);
        checkOutput("rst_done", 64'(ifc.done), 64'd0);
        checkOutput("rst_result", 64'(ifc.result), 64'd0);
        checkOutput("rst_zero", 64'(ifc.zero), 64'd0);
        checkOutput("rst_cout", 64'(ifc.cout), 64'd0);
        checkOutput("rst_ovf", 64'(ifc.overflow), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, -1, '0, lat);
            checkOutput($sformatf("vec%0d_result", i), 64'(ifc.result), 64'(vecs[i].r));
            checkOutput($sformatf("vec%0d_zero", i), 64'(ifc.zero), 64'(vecs[i].z));
            checkOutput($sformatf("vec%0d_cout", i), 64'(ifc.cout), 64'(vecs[i].c));
            checkOutput($sformatf("vec%0d_ovf", i), 64'(ifc.overflow), 64'(vecs[i].v));
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // A start pulse mid-operation must not disturb the latched operands
        applyStimulus(3'b010, 32'd1, 32'd1, 10, 32'd9, lat);
        checkOutput("ignored_start_result", 64'(ifc.result), 64'd2);
        runChecked("back_to_back", 3'b010, 32'd20, 32'd22, -1, '0);

        // Reset in the middle of an SLT aborts with no done pulse
        @(negedge clk);
        ifc.a     = 32'd3;
        ifc.b     = 32'd5;
        ifc.aluop = 3'b111;
        ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        checkOutput("abort_busy_before", 64'(ifc.busy), 64'd1);
        repeat (38) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(ifc.busy), 64'd0);
        checkOutput("abort_result", 64'(ifc.result), 64'd0);
        sawDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ifc.done) sawDone = 1'b1;
        end
        reset_n = 1'b1;
        repeat (70) begin
            @(negedge clk);
            if (ifc.done) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 64'(sawDone), 64'd0);
        applyStimulus(3'b010, 32'd2, 32'd2, -1, '0, lat);
        checkOutput("after_abort_result", 64'(ifc.result), 64'd4);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] av;
            logic [W-1:0] bv;
            op = 3'($urandom_range(0, 7));
            av = (i % 5 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            bv = (i % 7 == 0) ? av : W'($urandom);
            runChecked($sformatf("rnd%0d_op%0d", i, op), op, av, bv, -1, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
